// File: rtl/h264_nc_context.sv
// CAVLC neighbour-context store: per-4x4 TotalCoeff for luma/Cb/Cr (4:2:0) and predicted nC.
// Optional H264_NC_WRITE_BYPASS_EN forwards a same-cycle write into the nA/nB lookup.
module h264_nc_context #(
  parameter int unsigned MBWIDTH = 22,
  parameter int unsigned MBWBITS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       newslice_i,
  input  logic       newline_i,
  input  logic       mb_done_i,
  input  logic       wr_valid_i,
  input  logic [1:0] wr_comp_i,
  input  logic [1:0] wr_bx_i,
  input  logic [1:0] wr_by_i,
  input  logic [4:0] wr_tc_i,
  input  logic       req_valid_i,
  input  logic [1:0] req_comp_i,
  input  logic [1:0] req_bx_i,
  input  logic [1:0] req_by_i,
  output logic       nc_valid_o,
  output logic [4:0] nc_out_o
);

  localparam int unsigned YTopN = MBWIDTH * 4;
  localparam int unsigned CTopN = MBWIDTH * 2;

  localparam logic [1:0] CompY  = 2'd0;
  localparam logic [1:0] CompCb = 2'd1;
  localparam logic [1:0] CompCr = 2'd2;

  logic [MBWBITS-1:0] mbx_q, mbx_d;

  logic [3:0]       left_y_vld_q, left_y_vld_d;
  logic [1:0]       left_cb_vld_q, left_cb_vld_d;
  logic [1:0]       left_cr_vld_q, left_cr_vld_d;
  logic [YTopN-1:0] top_y_vld_q, top_y_vld_d;
  logic [CTopN-1:0] top_cb_vld_q, top_cb_vld_d;
  logic [CTopN-1:0] top_cr_vld_q, top_cr_vld_d;

  logic [4:0] left_y_val_q  [4];
  logic [4:0] left_cb_val_q [2];
  logic [4:0] left_cr_val_q [2];
  logic [4:0] top_y_val_q   [YTopN];
  logic [4:0] top_cb_val_q  [CTopN];
  logic [4:0] top_cr_val_q  [CTopN];

  logic       nc_valid_q, nc_valid_d;
  logic [4:0] nc_out_q, nc_out_d;

  logic               clr_left;
  logic               wr_en;
  logic [4:0]         wr_tc_sat;
  logic [MBWBITS+1:0] wr_y_idx;
  logic [MBWBITS:0]   wr_c_idx;
  logic [MBWBITS-1:0] req_mbx;
  logic [MBWBITS+1:0] req_y_idx;
  logic [MBWBITS:0]   req_c_idx;

  // Any clear drops a same-cycle write.
  assign clr_left  = newslice_i | newline_i;
  assign wr_en     = wr_valid_i & ~clr_left & (wr_comp_i != 2'd3);
  assign wr_tc_sat = (wr_tc_i > 5'd16) ? 5'd16 : wr_tc_i;
  assign wr_y_idx  = {mbx_q, wr_bx_i};
  assign wr_c_idx  = {mbx_q, wr_bx_i[0]};

  // Requests observe the post-clear column counter.
  assign req_mbx   = clr_left ? '0 : mbx_q;
  assign req_y_idx = {req_mbx, req_bx_i};
  assign req_c_idx = {req_mbx, req_bx_i[0]};

  always_comb begin
    mbx_d = mbx_q;
    if (clr_left) begin
      mbx_d = '0;
    end else if (mb_done_i) begin
      mbx_d = (mbx_q == MBWBITS'(MBWIDTH - 1)) ? '0 : mbx_q + 1'b1;
    end
  end

  always_comb begin
    left_y_vld_d  = left_y_vld_q;
    left_cb_vld_d = left_cb_vld_q;
    left_cr_vld_d = left_cr_vld_q;
    top_y_vld_d   = top_y_vld_q;
    top_cb_vld_d  = top_cb_vld_q;
    top_cr_vld_d  = top_cr_vld_q;
    if (newslice_i) begin
      left_y_vld_d  = '0;
      left_cb_vld_d = '0;
      left_cr_vld_d = '0;
      top_y_vld_d   = '0;
      top_cb_vld_d  = '0;
      top_cr_vld_d  = '0;
    end else if (newline_i) begin
      left_y_vld_d  = '0;
      left_cb_vld_d = '0;
      left_cr_vld_d = '0;
    end else if (wr_en) begin
      case (wr_comp_i)
        CompY: begin
          left_y_vld_d[wr_by_i] = 1'b1;
          top_y_vld_d[wr_y_idx] = 1'b1;
        end
        CompCb: begin
          left_cb_vld_d[wr_by_i[0]] = 1'b1;
          top_cb_vld_d[wr_c_idx]    = 1'b1;
        end
        CompCr: begin
          left_cr_vld_d[wr_by_i[0]] = 1'b1;
          top_cr_vld_d[wr_c_idx]    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mbx_q         <= '0;
      left_y_vld_q  <= '0;
      left_cb_vld_q <= '0;
      left_cr_vld_q <= '0;
      top_y_vld_q   <= '0;
      top_cb_vld_q  <= '0;
      top_cr_vld_q  <= '0;
      nc_valid_q    <= 1'b0;
      nc_out_q      <= '0;
    end else begin
      mbx_q         <= mbx_d;
      left_y_vld_q  <= left_y_vld_d;
      left_cb_vld_q <= left_cb_vld_d;
      left_cr_vld_q <= left_cr_vld_d;
      top_y_vld_q   <= top_y_vld_d;
      top_cb_vld_q  <= top_cb_vld_d;
      top_cr_vld_q  <= top_cr_vld_d;
      nc_valid_q    <= nc_valid_d;
      nc_out_q      <= nc_out_d;
    end
  end

  // Stored values need no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      case (wr_comp_i)
        CompY: begin
          left_y_val_q[wr_by_i] <= wr_tc_sat;
          top_y_val_q[wr_y_idx] <= wr_tc_sat;
        end
        CompCb: begin
          left_cb_val_q[wr_by_i[0]] <= wr_tc_sat;
          top_cb_val_q[wr_c_idx]    <= wr_tc_sat;
        end
        CompCr: begin
          left_cr_val_q[wr_by_i[0]] <= wr_tc_sat;
          top_cr_val_q[wr_c_idx]    <= wr_tc_sat;
        end
        default: ;
      endcase
    end
  end

  logic [4:0] a_val, b_val, nc;
  logic       a_vld, b_vld;
  logic [5:0] sum6;
`ifdef H264_NC_WRITE_BYPASS_EN
  logic       byp_a, byp_b;
`endif

  always_comb begin
    a_val = '0;
    a_vld = 1'b0;
    b_val = '0;
    b_vld = 1'b0;
    case (req_comp_i)
      CompY: begin
        a_val = left_y_val_q[req_by_i];
        a_vld = left_y_vld_q[req_by_i];
        b_val = top_y_val_q[req_y_idx];
        b_vld = top_y_vld_q[req_y_idx];
      end
      CompCb: begin
        a_val = left_cb_val_q[req_by_i[0]];
        a_vld = left_cb_vld_q[req_by_i[0]];
        b_val = top_cb_val_q[req_c_idx];
        b_vld = top_cb_vld_q[req_c_idx];
      end
      CompCr: begin
        a_val = left_cr_val_q[req_by_i[0]];
        a_vld = left_cr_vld_q[req_by_i[0]];
        b_val = top_cr_val_q[req_c_idx];
        b_vld = top_cr_vld_q[req_c_idx];
      end
      default: ;
    endcase
    if (clr_left) a_vld = 1'b0;
    if (newslice_i) b_vld = 1'b0;
`ifdef H264_NC_WRITE_BYPASS_EN
    // wr_en implies no clear, so the write and the request share mbx_q.
    byp_a = 1'b0;
    byp_b = 1'b0;
    if (wr_en && (wr_comp_i == req_comp_i)) begin
      if (wr_comp_i == CompY) begin
        byp_a = (wr_by_i == req_by_i);
        byp_b = (wr_bx_i == req_bx_i);
      end else begin
        byp_a = (wr_by_i[0] == req_by_i[0]);
        byp_b = (wr_bx_i[0] == req_bx_i[0]);
      end
    end
    if (byp_a) begin
      a_val = wr_tc_sat;
      a_vld = 1'b1;
    end
    if (byp_b) begin
      b_val = wr_tc_sat;
      b_vld = 1'b1;
    end
`endif
  end

  assign sum6 = {1'b0, a_val} + {1'b0, b_val} + 6'd1;

  always_comb begin
    case ({a_vld, b_vld})
      2'b11:   nc = sum6[5:1];
      2'b10:   nc = a_val;
      2'b01:   nc = b_val;
      default: nc = '0;
    endcase
    if (req_comp_i == 2'd3) nc = '0;
    nc_valid_d = req_valid_i;
    nc_out_d   = req_valid_i ? nc : '0;
  end

  assign nc_valid_o = nc_valid_q;
  assign nc_out_o   = nc_out_q;

endmodule

// File: tb/tb_h264_nc_context.sv
// Directed self-checking bench for h264_nc_context; expectations are hand-computed nC values.
`timescale 1ns/1ps
module tb_h264_nc_context;

  localparam int unsigned MBWIDTH = 22;
  localparam int unsigned MBWBITS = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       newslice, newline, mb_done, wr_valid, req_valid;
  logic [1:0] wr_comp, wr_bx, wr_by, req_comp, req_bx, req_by;
  logic [4:0] wr_tc;
  logic       nc_valid;
  logic [4:0] nc_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  h264_nc_context #(.MBWIDTH(MBWIDTH), .MBWBITS(MBWBITS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .newslice_i (newslice),
    .newline_i  (newline),
    .mb_done_i  (mb_done),
    .wr_valid_i (wr_valid),
    .wr_comp_i  (wr_comp),
    .wr_bx_i    (wr_bx),
    .wr_by_i    (wr_by),
    .wr_tc_i    (wr_tc),
    .req_valid_i(req_valid),
    .req_comp_i (req_comp),
    .req_bx_i   (req_bx),
    .req_by_i   (req_by),
    .nc_valid_o (nc_valid),
    .nc_out_o   (nc_out)
  );

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    newslice = 0; newline = 0; mb_done = 0; wr_valid = 0; req_valid = 0;
    wr_comp = 0; wr_bx = 0; wr_by = 0; wr_tc = 0; req_comp = 0; req_bx = 0; req_by = 0;
  endtask

  task automatic set_wr(input logic [1:0] c, input logic [1:0] bx, input logic [1:0] by,
                        input logic [4:0] tc);
    wr_valid = 1; wr_comp = c; wr_bx = bx; wr_by = by; wr_tc = tc;
  endtask

  task automatic set_req(input logic [1:0] c, input logic [1:0] bx, input logic [1:0] by);
    req_valid = 1; req_comp = c; req_bx = bx; req_by = by;
  endtask

  task automatic wr(input logic [1:0] c, input logic [1:0] bx, input logic [1:0] by,
                    input logic [4:0] tc);
    set_wr(c, bx, by, tc);
    cyc();
    idle_inputs();
  endtask

  // Request issued now; the registered answer is sampled one cycle later.
  task automatic req(input string tag, input logic [1:0] c, input logic [1:0] bx,
                     input logic [1:0] by, input logic [4:0] exp);
    set_req(c, bx, by);
    cyc();
    idle_inputs();
    check({tag, ".valid"}, {5'd0, nc_valid}, 6'd1);
    check({tag, ".nc"}, {1'b0, nc_out}, {1'b0, exp});
  endtask

  task automatic pulse_newslice();
    newslice = 1; cyc(); idle_inputs();
  endtask

  task automatic pulse_mb_done();
    mb_done = 1; cyc(); idle_inputs();
  endtask

  initial begin
    idle_inputs();
    #12;
    check("reset.valid", {5'd0, nc_valid}, 6'd0);
    check("reset.nc", {1'b0, nc_out}, 6'd0);
    #1 rst_n = 1;
    cyc();

    // Latency: nothing until the edge after the request, then exactly one cycle of valid.
    set_req(0, 0, 0);
    check("lat.before", {5'd0, nc_valid}, 6'd0);
    cyc();
    idle_inputs();
    check("lat.valid", {5'd0, nc_valid}, 6'd1);
    check("lat.nc", {1'b0, nc_out}, 6'd0);
    cyc();
    check("lat.drop", {5'd0, nc_valid}, 6'd0);

    // Single-neighbour predictions.
    pulse_newslice();
    wr(0, 0, 0, 7);
    req("a_only", 0, 1, 0, 7);
    req("b_only", 0, 0, 1, 7);

    // Both neighbours, rounding and saturation.
    wr(0, 0, 1, 5);
    wr(0, 1, 0, 8);
    req("avg_5_8", 0, 1, 1, 7);
    wr(0, 0, 1, 16);
    wr(0, 1, 0, 16);
    req("avg_16_16", 0, 1, 1, 16);
    wr(0, 0, 1, 31);
    req("clamp_31", 0, 1, 1, 16);

    // Chroma planes are independent of each other and of luma.
    pulse_newslice();
    wr(1, 0, 0, 3);
    req("cb_a", 1, 1, 0, 3);
    req("cb_b", 1, 0, 1, 3);
    req("cr_empty", 2, 1, 0, 0);
    req("luma_empty", 0, 1, 0, 0);
    req("comp3", 3, 1, 0, 0);

    // Fill one MB row; the final mb_done wraps mbx back to 0.
    pulse_newslice();
    for (int mb = 0; mb < int'(MBWIDTH); mb++) begin
      for (int bx = 0; bx < 4; bx++) begin
        wr(0, 2'(bx), 0, 1);
        wr(0, 2'(bx), 3, 5'((mb + bx + 2) % 17));
      end
      pulse_mb_done();
    end
    req("wrap_00", 0, 0, 0, 2);
    req("wrap_03", 0, 0, 3, 6);

    // mb_done alongside newline loses; left context is dropped, top row persists.
    pulse_mb_done();
    newline = 1; mb_done = 1; cyc(); idle_inputs();
    req("nl_03", 0, 0, 3, 2);
    req("nl_00", 0, 0, 0, 2);
    pulse_mb_done();
    req("nl_mb1", 0, 1, 3, 4);
    pulse_newslice();
    req("slice_00", 0, 0, 0, 0);

    // A write alongside newslice is dropped.
    newslice = 1; set_wr(0, 0, 0, 9); cyc(); idle_inputs();
    req("drop_a", 0, 1, 0, 0);
    req("drop_b", 0, 0, 1, 0);

    // A request alongside newline sees the left entries already cleared.
    wr(0, 0, 0, 5);
    newline = 1; set_req(0, 1, 0); cyc(); idle_inputs();
    check("nl_req.valid", {5'd0, nc_valid}, 6'd1);
    check("nl_req.nc", {1'b0, nc_out}, 6'd0);

    // Same-cycle write into the left neighbour of the block being requested.
    pulse_newslice();
    wr(0, 0, 0, 3);
    set_wr(0, 3, 1, 9);
    set_req(0, 0, 1);
    cyc();
    idle_inputs();
`ifdef H264_NC_WRITE_BYPASS_EN
    check("bypass", {1'b0, nc_out}, 6'd6);
`else
    check("no_bypass", {1'b0, nc_out}, 6'd3);
`endif
    req("after_wr", 0, 0, 1, 6);

    // Reset arriving while a response is pending suppresses it and clears context.
    set_req(0, 1, 0);
    @(posedge clk);
    #1 idle_inputs();
    #1 rst_n = 0;
    #1 check("rst_mid.valid", {5'd0, nc_valid}, 6'd0);
    cyc();
    #3 rst_n = 1;
    cyc();
    check("rst_after.valid", {5'd0, nc_valid}, 6'd0);
    req("rst_after", 0, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/h264_nc_context.md
# h264_nc_context

Parametrised CAVLC neighbour-context store for the H.264 intra encoder. It holds per-4x4-block TotalCoeff values for luma, Cb and Cr in 4:2:0, and returns the predicted nC for each block the CAVLC stage is about to code. It tracks left and top availability across macroblock, line and slice boundaries with per-entry valid bits. Successor to the fixed-width left/top nC arrays in the encoder top level; it sits between the coefficient buffer's neighbour-request outputs and the CAVLC NIN input.

## Interface
- MBWIDTH, 22, macroblocks per line (352/16).
- MBWBITS, 5, width of MB column counter; 2**MBWBITS >= MBWIDTH.
- clk  in  1  clock; all state on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- newslice  in  1  start of slice: clear all left and top valid bits, mbx<=0.
- newline  in  1  start of MB row: clear left valid bits, mbx<=0.
- mb_done  in  1  current macroblock finished: mbx<=mbx+1.
- wr_valid  in  1  store a TotalCoeff value.
- wr_comp  in  2  0=luma, 1=Cb, 2=Cr; 3 ignored.
- wr_bx, wr_by  in  2 each  block position within the MB; chroma uses bit 0 only.
- wr_tc  in  5  TotalCoeff, 0..16.
- req_valid  in  1  request nC.
- req_comp, req_bx, req_by  in  2 each  block being coded.
- nc_valid  out  1  nc_out valid.
- nc_out  out  5  predicted nC, 0..16.

## Operation
- Storage: left arrays of 4/2/2 entries (luma/Cb/Cr), indexed by by. Top arrays of MBWIDTH*4 / *2 / *2 entries, indexed by {mbx,bx}. Each entry is 5-bit value plus valid bit.
- Write:
  - left[comp][by] <= tc and top[comp][{mbx,bx}] <= tc; both valid bits set.
  - wr_tc > 16 is stored as 16.
- Request:
  - nA = left[comp][by], availA = its valid bit.
  - nB = top[comp][{mbx,bx}], availB = its valid bit.
  - Blocks are written in coding order, so the left entry always holds the block immediately left, whether in this MB or the previous one. The top entry likewise holds the block immediately above.
- nC rule:
  - both available: (nA+nB+1)>>1, computed in 6 bits.
  - only A available: nA.
  - only B available: nB.
  - neither available: 0.
- MB counter:
  - mbx wraps from MBWIDTH-1 to 0 on mb_done.
  - newslice/newline take priority over mb_done.
  - Top entries are never cleared by newline, so row r sees row r-1 only within the same slice.
- Priority in one cycle: newslice > newline > wr_valid.
  - A write in the same cycle as a clear is dropped.
  - A request in the same cycle as a clear sees the post-clear state (unavailable).
- Invalid comp (3) on write: no state change. On request: nc_valid=1, nc_out=0.

## Timing
- Reset: nc_valid=0, nc_out=0, mbx=0, all valid bits 0; stored values are don't-care.
- Latency: nc_valid asserts exactly one cycle after req_valid, with nc_out registered. Requests are accepted every cycle; there is no back-pressure.
- Writes take effect for requests issued on the following cycle.
- Same-cycle write and request to the neighbour location: see Configuration.
- rst_n assertion mid-request suppresses that request's nc_valid.

## Configuration
- H264_NC_WRITE_BYPASS_EN defined:
  - A request in the same cycle as a write forwards wr_tc into the matching nA and/or nB path and treats it as available.
  - Match is same comp and same by (left), or same comp and same {mbx,bx} (top).
- Undefined:
  - The request reads pre-write contents.
  - Upstream must leave one idle cycle between a write and a dependent request.

## Test plan
- Reset, then request luma (0,0) -> nc_valid one cycle later, nc_out=0.
- After newslice, write luma (0,0)=7, then request (1,0) -> 7 (A only); request (0,1) -> 7 (B only).
- Write left=5 and top=8, then request a block with both neighbours -> (5+8+1)>>1=7. With 16 and 16 -> 16.
- Fill row 0 over MBWIDTH MBs, newline, then request MB0 block (0,0) -> top value of row 0, left unavailable. Issue newslice and repeat -> 0.
- mb_done at mbx=MBWIDTH-1 -> mbx=0. mb_done together with newline -> mbx=0, left valid bits cleared.
- Same-cycle write tc=9 with a dependent request:
  - with H264_NC_WRITE_BYPASS_EN, old neighbour 3 -> (9+3+1)>>1=6;
  - without it -> pre-write result.
